core_run_controller: RTL and testbench

//  Sequences the single-cycle RISC-V core on the board. It turns a raw push button and
//  the run switch into a clean core reset, a per-cycle commit enable (o_clk_en) and a

---
 rtl/core_run_controller.sv | 121 ++++++++++++
 tb/tb_core_run_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_run_controller.sv
// Run/step/halt sequencer for the single-cycle core: debounces the step key, holds the
// core in reset after power-up or a soft restart, gates commits and counts committed cycles.
module core_run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_key_n,
    input  logic             i_run,
    input  logic             i_halt,
    output logic             o_core_reset,
    output logic             o_clk_en,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_step_cnt
);

    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        IDLE     = 3'd1,
        STEP     = 3'd2,
        RUN      = 3'd3,
        HALT     = 3'd4
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              key_s1;
    logic              key_s2;
    logic              key_lvl;
    logic [DB_W-1:0]   db_cnt;
    logic              press;

    // press is a registered one-cycle pulse on the debounced 1->0 flip
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            key_s1  <= 1'b1;
            key_s2  <= 1'b1;
            key_lvl <= 1'b1;
            db_cnt  <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= i_key_n;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2 == key_lvl) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                key_lvl <= key_s2;
                db_cnt  <= '0;
                press   <= key_lvl;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= RST_HOLD;
            hold_cnt   <= HOLD_LAST;
            o_step_cnt <= '0;
        end else begin
            if (o_clk_en && (o_step_cnt != '1)) begin
                o_step_cnt <= o_step_cnt + 1'b1;
            end
            case (state)
                RST_HOLD: begin
                    if (hold_cnt == '0) begin
                        state <= i_run ? RUN : IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (i_halt) begin
                        state <= HALT;
                    end else if (i_run) begin
                        state <= RUN;
                    end else if (press) begin
                        state <= STEP;
                    end
                end
                STEP: begin
                    state <= IDLE;
                end
                RUN: begin
                    if (i_halt) begin
                        state <= HALT;
                    end else if (!i_run) begin
                        state <= IDLE;
                    end
                end
                HALT: begin
                    if (press) begin
                        state      <= RST_HOLD;
                        hold_cnt   <= HOLD_LAST;
                        o_step_cnt <= '0;
                    end
                end
                default: begin
                    state      <= RST_HOLD;
                    hold_cnt   <= HOLD_LAST;
                    o_step_cnt <= '0;
                end
            endcase
        end
    end

    // halt gates the enable combinationally so the halting cycle commits nothing
    assign o_core_reset = (state == RST_HOLD);
    assign o_clk_en     = (state == STEP) || ((state == RUN) && !i_halt);
    assign o_state      = state;

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed scenarios plus randomized key/run/halt/reset
// traffic compared each cycle against a cycle-level behavioural model.
module tb_core_run_controller;

    localparam int D = 4;
    localparam int H = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         i_reset;
    logic         i_key_n;
    logic         i_run;
    logic         i_halt;
    logic         o_core_reset;
    logic         o_clk_en;
    logic [2:0]   o_state;
    logic [W-1:0] o_step_cnt;

    core_run_controller #(
        .DEBOUNCE_CYCLES(D),
        .RST_HOLD_CYCLES(H),
        .CNT_W(W)
    ) dut (
        .i_clk(clk),
        .i_reset(i_reset),
        .i_key_n(i_key_n),
        .i_run(i_run),
        .i_halt(i_halt),
        .o_core_reset(o_core_reset),
        .o_clk_en(o_clk_en),
        .o_state(o_state),
        .o_step_cnt(o_step_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: mode 0 RST_HOLD, 1 IDLE, 2 STEP, 3 RUN, 4 HALT
    int m_state = 0;
    int m_hold  = H;
    int m_cnt   = 0;
    int m_run   = 0;
    bit m_lvl   = 1'b1;
    bit m_press = 1'b0;
    bit sync_q[$];

    bit armed = 1'b0;
    int pulses = 0;
    int rst_cycles = 0;
    bit s_en;
    bit s_rst;
    int s_state;
    int s_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit key, input bit run, input bit halt);
        bit synced;
        bit en;
        bit was_press;
        if (rst) begin
            m_state = 0;
            m_hold  = H;
            m_cnt   = 0;
            m_run   = 0;
            m_lvl   = 1'b1;
            m_press = 1'b0;
            sync_q  = '{1'b1, 1'b1};
            return;
        end
        en = (m_state == 2) || (m_state == 3 && !halt);
        was_press = m_press;
        m_press = 1'b0;
        synced = sync_q.pop_front();
        sync_q.push_back(key);
        if (synced != m_lvl) begin
            m_run++;
            if (m_run == D) begin
                m_press = m_lvl;
                m_lvl   = synced;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        if (en && m_cnt < (1 << W) - 1) m_cnt++;
        case (m_state)
            0: begin
                m_hold--;
                if (m_hold == 0) m_state = run ? 3 : 1;
            end
            1: begin
                if (halt) m_state = 4;
                else if (run) m_state = 3;
                else if (was_press) m_state = 2;
            end
            2: m_state = 1;
            3: begin
                if (halt) m_state = 4;
                else if (!run) m_state = 1;
            end
            default: begin
                if (was_press) begin
                    m_state = 0;
                    m_hold  = H;
                    m_cnt   = 0;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit rst, input bit key, input bit run, input bit halt);
        @(negedge clk);
        i_reset = rst;
        i_key_n = key;
        i_run   = run;
        i_halt  = halt;
        #1;
        if (armed) begin
            check("core_reset", o_core_reset, m_state == 0);
            check("clk_en", o_clk_en, (m_state == 2) || (m_state == 3 && !halt));
            check("state", o_state, m_state);
            check("step_cnt", o_step_cnt, m_cnt);
        end
        s_en    = o_clk_en;
        s_rst   = o_core_reset;
        s_state = o_state;
        s_cnt   = o_step_cnt;
        pulses     += o_clk_en ? 1 : 0;
        rst_cycles += o_core_reset ? 1 : 0;
        @(posedge clk);
        model_step(rst, key, run, halt);
    endtask

    initial begin
        int p0;
        bit key;
        bit run;
        bit halt;
        bit rst;
        int klen;

        i_reset = 1'b1;
        i_key_n = 1'b1;
        i_run   = 1'b0;
        i_halt  = 1'b0;
        sync_q  = '{1'b1, 1'b1};

        // 1: reset, hold, then IDLE
        cycle(1, 1, 0, 0);
        armed = 1'b1;
        cycle(1, 1, 0, 0);
        check("t1_reset_rst", s_rst, 1);
        check("t1_reset_en", s_en, 0);
        check("t1_reset_state", s_state, 0);
        rst_cycles = 0;
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
        check("t1_hold_len", rst_cycles, 3);
        cycle(0, 1, 0, 0);
        check("t1_idle_state", s_state, 1);
        check("t1_idle_cnt", s_cnt, 0);

        // 2: short glitch ignored, long press gives exactly one step
        p0 = pulses;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        check("t2_glitch", pulses - p0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        check("t2_one_step", pulses - p0, 1);
        check("t2_cnt", s_cnt, 1);

        // 3: bouncing key then stable low
        p0 = pulses;
        for (int i = 0; i < 20; i++) cycle(0, ((i / 2) % 2) != 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
        check("t3_bounce", pulses - p0, 1);

        // 4: free-run 10 cycles, then halt
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        p0 = pulses;
        for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0);
        check("t4_run_pulses", pulses - p0, 10);
        cycle(0, 1, 1, 1);
        check("t4_halt_en", s_en, 0);
        check("t4_halt_cnt_pre", s_cnt, 10);
        cycle(0, 1, 1, 1);
        check("t4_halt_state", s_state, 4);
        check("t4_halt_cnt", s_cnt, 10);

        // 5: soft restart from HALT
        rst_cycles = 0;
        for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0);
        check("t5_hold_len", rst_cycles, 3);
        check("t5_state", s_state, 1);
        check("t5_cnt", s_cnt, 0);

        // 6: reset mid-run at 0xFE, then saturation
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        for (int i = 0; i < 254; i++) cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        check("t6_cnt_fe", s_cnt, 8'hFE);
        cycle(0, 1, 1, 0);
        check("t6_abort_rst", s_rst, 1);
        check("t6_abort_en", s_en, 0);
        check("t6_abort_cnt", s_cnt, 0);
        for (int i = 0; i < 302; i++) cycle(0, 1, 1, 0);
        check("t6_saturate", s_cnt, 8'hFF);

        // randomized traffic against the model
        key = 1'b1;
        run = 1'b0;
        halt = 1'b0;
        klen = 0;
        for (int i = 0; i < 3000; i++) begin
            if (klen == 0) begin
                key  = ($urandom_range(0, 1) != 0);
                klen = $urandom_range(1, 12);
            end
            klen--;
            if ($urandom_range(0, 15) == 0) run = ~run;
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            rst = ($urandom_range(0, 299) == 0);
            cycle(rst, key, run, halt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
